// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus.
// Formats store lanes and strobes, merges load data, and stalls the pipeline until the access finishes.
module mem_access_unit #(
  parameter int DATA_W       = 32,
  parameter bit UNALIGNED_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [5:0]            op,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  flush,
  output logic                  stall,
  output logic [31:0]           rdata_out,
  output logic                  adelM,
  output logic                  adesM,
  output logic [31:0]           bad_addr,
  output logic                  dreq,
  output logic                  dwr,
  output logic [1:0]            dsize,
  output logic [31:0]           daddr,
  output logic [DATA_W/8-1:0]   dwstrb,
  output logic [DATA_W-1:0]     dwdata,
  input  logic                  daddr_ok,
  input  logic                  ddata_ok,
  input  logic [DATA_W-1:0]     drdata
);

  localparam int BYTES = DATA_W / 8;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t state, state_n;

  logic [1:0]       off;
  logic             lane;
  logic             valid_op, is_store, unal, mis_h, mis_w, fault, accept, capture;
  logic [1:0]       size_n;
  logic [3:0]       strb32;
  logic [31:0]      data32;
  logic [BYTES-1:0] strb_ext;

  logic [5:0]       op_q;
  logic [1:0]       off_q;
  logic             lane_q;
  logic [31:0]      rt_q;

  logic [31:0]      m, load_val;
  logic [7:0]       bsel;
  logic [15:0]      hsel;

  assign off  = addr[1:0];
  assign lane = (DATA_W == 64) ? addr[2] : 1'b0;

  always_comb begin
    valid_op = 1'b0;
    is_store = 1'b0;
    unal     = 1'b0;
    mis_h    = 1'b0;
    mis_w    = 1'b0;
    size_n   = 2'd2;
    strb32   = 4'b0000;
    data32   = wdata;
    case (op)
      OP_LB, OP_LBU: begin
        valid_op = 1'b1;
        size_n   = 2'd0;
      end
      OP_LH, OP_LHU: begin
        valid_op = 1'b1;
        size_n   = 2'd1;
        mis_h    = 1'b1;
      end
      OP_LW: begin
        valid_op = 1'b1;
        mis_w    = 1'b1;
      end
      OP_LWL, OP_LWR: begin
        valid_op = UNALIGNED_EN;
        unal     = 1'b1;
      end
      OP_SB: begin
        valid_op = 1'b1;
        is_store = 1'b1;
        size_n   = 2'd0;
        strb32   = 4'b0001 << off;
        data32   = {4{wdata[7:0]}};
      end
      OP_SH: begin
        valid_op = 1'b1;
        is_store = 1'b1;
        size_n   = 2'd1;
        mis_h    = 1'b1;
        strb32   = 4'b0011 << off;
        data32   = {2{wdata[15:0]}};
      end
      OP_SW: begin
        valid_op = 1'b1;
        is_store = 1'b1;
        mis_w    = 1'b1;
        strb32   = 4'b1111;
      end
      OP_SWL: begin
        valid_op = UNALIGNED_EN;
        is_store = 1'b1;
        unal     = 1'b1;
        strb32   = 4'b1111 >> (2'd3 - off);
        data32   = wdata >> {2'd3 - off, 3'b000};
      end
      OP_SWR: begin
        valid_op = UNALIGNED_EN;
        is_store = 1'b1;
        unal     = 1'b1;
        strb32   = 4'b1111 << off;
        data32   = wdata << {off, 3'b000};
      end
      default: ;
    endcase
    strb_ext      = '0;
    strb_ext[3:0] = strb32;
  end

  assign fault    = (mis_h & addr[0]) | (mis_w & (addr[1:0] != 2'b00));
  assign adelM    = mem_en & valid_op & ~is_store & fault;
  assign adesM    = mem_en & valid_op & is_store & fault;
  assign bad_addr = (adelM | adesM) ? addr : 32'h0;
  assign accept   = mem_en & valid_op & ~fault & ~flush;

  // Load formatting works on the 32-bit word lane picked at request time.
  always_comb begin
    m    = lane_q ? drdata[DATA_W-1 -: 32] : drdata[31:0];
    bsel = m[{off_q, 3'b000} +: 8];
    hsel = m[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LB:   load_val = {{24{bsel[7]}}, bsel};
      OP_LBU:  load_val = {24'h0, bsel};
      OP_LH:   load_val = {{16{hsel[15]}}, hsel};
      OP_LHU:  load_val = {16'h0, hsel};
      OP_LWL:  load_val = (m << {2'd3 - off_q, 3'b000}) |
                          (rt_q & (32'h00FF_FFFF >> {off_q, 3'b000}));
      OP_LWR:  load_val = (m >> {off_q, 3'b000}) |
                          (rt_q & ~(32'hFFFF_FFFF >> {off_q, 3'b000}));
      default: load_val = m;
    endcase
  end

  // A flush that races with completion still drops the result; a flush after
  // the address was accepted must drain the pending data beat.
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_REQ;
          stall   = 1'b1;
        end
      end
      S_REQ: begin
        stall = ~flush;
        if (daddr_ok) begin
          if (ddata_ok) begin
            state_n = flush ? S_IDLE : S_DONE;
            capture = ~flush;
          end else begin
            state_n = flush ? S_DRAIN : S_WAIT;
          end
        end else if (flush) begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        stall = ~flush;
        if (ddata_ok) begin
          state_n = flush ? S_IDLE : S_DONE;
          capture = ~flush;
        end else if (flush) begin
          state_n = S_DRAIN;
        end
      end
      S_DONE: state_n = S_IDLE;
      S_DRAIN: begin
        stall = mem_en & ~flush;
        if (ddata_ok) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dreq      <= 1'b0;
      dwr       <= 1'b0;
      dsize     <= 2'd0;
      daddr     <= 32'h0;
      dwstrb    <= '0;
      dwdata    <= '0;
      rdata_out <= 32'h0;
      op_q      <= 6'h0;
      off_q     <= 2'd0;
      lane_q    <= 1'b0;
      rt_q      <= 32'h0;
    end else begin
      state <= state_n;
      dreq  <= (state_n == S_REQ);
      if (state == S_IDLE && accept) begin
        dwr    <= is_store;
        dsize  <= size_n;
        daddr  <= unal ? {addr[31:2], 2'b00} : addr;
        dwstrb <= is_store ? (strb_ext << {lane, 2'b00}) : '0;
        dwdata <= {(DATA_W/32){data32}};
        op_q   <= op;
        off_q  <= off;
        lane_q <= lane;
        rt_q   <= wdata;
      end
      if (capture && !dwr) rdata_out <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (32-bit and 64-bit instances).
module tb_mem_access_unit;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LWL = 6'h22, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] LWR = 6'h26, SB = 6'h28, SH = 6'h29, SWL = 6'h2A, SW = 6'h2B, SWR = 6'h2E;

  typedef struct packed {
    logic        dwr;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [3:0]  dwstrb;
    logic [31:0] dwdata;
  } bus_t;

  logic clk = 1'b0, rst = 1'b1;
  logic mem_en = 0, flush = 0, daddr_ok = 0, ddata_ok = 0;
  logic [5:0] op = 0;
  logic [31:0] addr = 0, wdata = 0, drdata = 0;
  logic stall, adelM, adesM, dreq, dwr;
  logic [31:0] rdata_out, bad_addr, daddr, dwdata;
  logic [1:0] dsize;
  logic [3:0] dwstrb;

  logic mem_en_w = 0, flush_w = 0, daddr_ok_w = 0, ddata_ok_w = 0;
  logic [63:0] drdata_w = 0;
  logic stall_w, adel_w, ades_w, dreq_w, dwr_w;
  logic [31:0] rdata_w, bad_w, daddr_w;
  logic [1:0] dsize_w;
  logic [7:0] dwstrb_w;
  logic [63:0] dwdata_w;

  bus_t bus_q[$];
  logic [32:0] rd_q[$];
  bus_t mon_e;
  logic [32:0] mon_r;
  logic prev_stall = 0, prev_flush = 0;
  int checks = 0, errors = 0, ns;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .UNALIGNED_EN(1'b1)) u32 (
    .clk(clk), .rst(rst), .mem_en(mem_en), .op(op), .addr(addr), .wdata(wdata), .flush(flush),
    .stall(stall), .rdata_out(rdata_out), .adelM(adelM), .adesM(adesM), .bad_addr(bad_addr),
    .dreq(dreq), .dwr(dwr), .dsize(dsize), .daddr(daddr), .dwstrb(dwstrb), .dwdata(dwdata),
    .daddr_ok(daddr_ok), .ddata_ok(ddata_ok), .drdata(drdata));

  mem_access_unit #(.DATA_W(64), .UNALIGNED_EN(1'b1)) u64 (
    .clk(clk), .rst(rst), .mem_en(mem_en_w), .op(op), .addr(addr), .wdata(wdata), .flush(flush_w),
    .stall(stall_w), .rdata_out(rdata_w), .adelM(adel_w), .adesM(ades_w), .bad_addr(bad_w),
    .dreq(dreq_w), .dwr(dwr_w), .dsize(dsize_w), .daddr(daddr_w), .dwstrb(dwstrb_w), .dwdata(dwdata_w),
    .daddr_ok(daddr_ok_w), .ddata_ok(ddata_ok_w), .drdata(drdata_w));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic bus_t mk(input logic w, input logic [1:0] s, input logic [31:0] a,
                              input logic [3:0] st, input logic [31:0] d);
    bus_t b;
    b.dwr = w; b.dsize = s; b.daddr = a; b.dwstrb = st; b.dwdata = d;
    return b;
  endfunction

  // Bus fields are checked every request cycle (stability) and retired on address acceptance;
  // a load result is retired when stall drops with the instruction still held.
  always @(negedge clk) begin
    if (!rst) begin
      if (dreq) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: daddr=%h, required no request", daddr);
        end else begin
          mon_e = bus_q[0];
          chk("bus_dwr", {63'h0, dwr}, {63'h0, mon_e.dwr});
          chk("bus_dsize", {62'h0, dsize}, {62'h0, mon_e.dsize});
          chk("bus_daddr", {32'h0, daddr}, {32'h0, mon_e.daddr});
          if (mon_e.dwr) begin
            chk("bus_dwstrb", {60'h0, dwstrb}, {60'h0, mon_e.dwstrb});
            chk("bus_dwdata", {32'h0, dwdata}, {32'h0, mon_e.dwdata});
          end
          if (daddr_ok) void'(bus_q.pop_front());
        end
      end
      if (mem_en && !stall && prev_stall && !flush && !prev_flush) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: rdata_out=%h, required no completion", rdata_out);
        end else begin
          mon_r = rd_q.pop_front();
          if (mon_r[32]) chk("load_result", {32'h0, rdata_out}, {32'h0, mon_r[31:0]});
        end
      end
    end
    prev_stall <= stall;
    prev_flush <= flush;
  end

  task automatic run(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w,
                     input int aw, input int dw, input logic [31:0] rd);
    int n;
    op = o; addr = a; wdata = w; mem_en = 1; n = 0;
    @(negedge clk); if (stall) n++;
    @(posedge clk); #1;
    repeat (aw) begin
      @(negedge clk); if (stall) n++;
      @(posedge clk); #1;
    end
    daddr_ok = 1;
    if (dw == 0) begin ddata_ok = 1; drdata = rd; end
    @(negedge clk); if (stall) n++;
    @(posedge clk); #1;
    daddr_ok = 0; ddata_ok = 0;
    if (dw > 0) begin
      repeat (dw - 1) begin
        @(negedge clk); if (stall) n++;
        @(posedge clk); #1;
      end
      ddata_ok = 1; drdata = rd;
      @(negedge clk); if (stall) n++;
      @(posedge clk); #1;
      ddata_ok = 0;
    end
    @(negedge clk);
    chk("done_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    mem_en = 0;
    @(posedge clk); #1;
    chk("stall_cycles", n, 2 + aw + dw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_dreq", {63'h0, dreq}, 64'h0);
    chk("rst_stall", {63'h0, stall}, 64'h0);
    chk("rst_rdata", {32'h0, rdata_out}, 64'h0);
    chk("rst_daddr", {32'h0, daddr}, 64'h0);
    chk("rst_dwstrb", {60'h0, dwstrb}, 64'h0);
    chk("rst_dwdata", {32'h0, dwdata}, 64'h0);
    chk("rst_dreq64", {63'h0, dreq_w}, 64'h0);
    @(posedge clk); #1;

    bus_q.push_back(mk(0, 0, 32'h1003, 0, 0));        rd_q.push_back({1'b1, 32'hFFFF_FF80});
    run(LB, 32'h1003, 0, 0, 0, 32'h80FF_FF00);
    bus_q.push_back(mk(0, 0, 32'h1003, 0, 0));        rd_q.push_back({1'b1, 32'h0000_0080});
    run(LBU, 32'h1003, 0, 0, 1, 32'h80FF_FF00);
    bus_q.push_back(mk(1, 1, 32'h2002, 4'b1100, 32'hABCD_ABCD)); rd_q.push_back({1'b0, 32'h0});
    run(SH, 32'h2002, 32'h1234_ABCD, 1, 0, 0);
    bus_q.push_back(mk(0, 2, 32'h4000, 0, 0));        rd_q.push_back({1'b1, 32'hCCDD_3344});
    run(LWL, 32'h4001, 32'h1122_3344, 0, 0, 32'hAABB_CCDD);
    bus_q.push_back(mk(0, 2, 32'h4000, 0, 0));        rd_q.push_back({1'b1, 32'h11AA_BBCC});
    run(LWR, 32'h4001, 32'h1122_3344, 0, 0, 32'hAABB_CCDD);
    bus_q.push_back(mk(1, 2, 32'h5000, 4'b1100, 32'h3344_0000)); rd_q.push_back({1'b0, 32'h0});
    run(SWR, 32'h5002, 32'h1122_3344, 0, 0, 0);
    bus_q.push_back(mk(1, 2, 32'h8000, 4'b0011, 32'h0000_1122)); rd_q.push_back({1'b0, 32'h0});
    run(SWL, 32'h8001, 32'h1122_3344, 0, 0, 0);
    bus_q.push_back(mk(1, 0, 32'h9001, 4'b0010, 32'hA5A5_A5A5)); rd_q.push_back({1'b0, 32'h0});
    run(SB, 32'h9001, 32'h0000_00A5, 0, 0, 0);
    bus_q.push_back(mk(0, 1, 32'h6002, 0, 0));        rd_q.push_back({1'b1, 32'hFFFF_8001});
    run(LH, 32'h6002, 0, 0, 0, 32'h8001_7FFF);
    bus_q.push_back(mk(0, 1, 32'h6002, 0, 0));        rd_q.push_back({1'b1, 32'h0000_8001});
    run(LHU, 32'h6002, 0, 0, 0, 32'h8001_7FFF);
    bus_q.push_back(mk(0, 2, 32'h7000, 0, 0));        rd_q.push_back({1'b1, 32'h1234_5678});
    run(LW, 32'h7000, 0, 3, 1, 32'h1234_5678);

    op = SW; addr = 32'h3001; wdata = 32'h5555_5555; mem_en = 1;
    @(negedge clk);
    chk("sw_mis_ades", {63'h0, adesM}, 64'h1);
    chk("sw_mis_adel", {63'h0, adelM}, 64'h0);
    chk("sw_mis_bad", {32'h0, bad_addr}, 64'h3001);
    chk("sw_mis_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sw_mis_noreq", {63'h0, dreq}, 64'h0);
    op = LH;
    #1;
    chk("lh_mis_adel", {63'h0, adelM}, 64'h1);
    mem_en = 0;
    #1;
    chk("bad_addr_idle", {32'h0, bad_addr}, 64'h0);
    @(posedge clk); #1;

    bus_q.push_back(mk(0, 2, 32'h0100, 0, 0));
    op = LW; addr = 32'h0100; mem_en = 1;
    @(posedge clk); #1;
    daddr_ok = 1;
    @(posedge clk); #1;
    daddr_ok = 0; flush = 1;
    @(negedge clk);
    chk("flush_stall", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    flush = 0; addr = 32'h0104;
    repeat (2) begin
      @(negedge clk);
      chk("drain_stall", {63'h0, stall}, 64'h1);
      chk("drain_noreq", {63'h0, dreq}, 64'h0);
      @(posedge clk); #1;
    end
    bus_q.push_back(mk(0, 2, 32'h0104, 0, 0));        rd_q.push_back({1'b1, 32'h600D_F00D});
    ddata_ok = 1; drdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("drain_last_stall", {63'h0, stall}, 64'h1);
    @(posedge clk); #1;
    ddata_ok = 0;
    @(negedge clk);
    chk("post_drain_accept", {63'h0, stall}, 64'h1);
    @(posedge clk); #1;
    daddr_ok = 1; ddata_ok = 1; drdata = 32'h600D_F00D;
    @(posedge clk); #1;
    daddr_ok = 0; ddata_ok = 0;
    @(posedge clk); #1;
    mem_en = 0;
    @(posedge clk); #1;

    op = SW; addr = 32'h0000_A004; wdata = 32'hCAFE_BABE; mem_en_w = 1;
    @(negedge clk);
    chk("w64_accept_stall", {63'h0, stall_w}, 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w64_dreq", {63'h0, dreq_w}, 64'h1);
    chk("w64_dwstrb", {56'h0, dwstrb_w}, 64'hF0);
    chk("w64_dwdata", dwdata_w, 64'hCAFE_BABE_CAFE_BABE);
    chk("w64_daddr", {32'h0, daddr_w}, 64'hA004);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_en_w = 0;
    @(negedge clk);
    chk("w64_rst_dreq", {63'h0, dreq_w}, 64'h0);
    chk("w64_rst_stall", {63'h0, stall_w}, 64'h0);
    ddata_ok_w = 1; drdata_w = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    ddata_ok_w = 0;
    @(negedge clk);
    chk("w64_late_stall", {63'h0, stall_w}, 64'h0);
    chk("w64_late_dreq", {63'h0, dreq_w}, 64'h0);
    chk("w64_late_rdata", {32'h0, rdata_w}, 64'h0);

    repeat (2) @(posedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
